// File: rtl/cmos_capture_win.sv
// DVP byte-stream capture: pixel assembly, frame-skip gate, crop window,
// per-frame line/pixel statistics and sticky partial-pixel error.
module cmos_capture_win #(
    parameter int IN_W          = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int BYTE_SWAP     = 0,
    parameter int SKIP_FRAMES   = 12,
    parameter int CNT_W         = 12,
    parameter int X_START       = 0,
    parameter int X_END         = 639,
    parameter int Y_START       = 0,
    parameter int Y_END         = 479
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic                          iInit_Done,
    input  logic                          iVSYNC,
    input  logic                          iHREF,
    input  logic [IN_W-1:0]               iDATA,
    output logic [IN_W*BYTES_PER_PIX-1:0] oDATA,
    output logic                          oVALID,
    output logic                          oSOF,
    output logic                          oEOL,
    output logic [CNT_W-1:0]              oX,
    output logic [CNT_W-1:0]              oY,
    output logic                          oARMED,
    output logic [CNT_W-1:0]              oLINE_LEN,
    output logic [CNT_W-1:0]              oLINES,
    output logic [7:0]                    oFRAME_CNT,
    output logic                          oERR_PARTIAL
);

    localparam int PW = IN_W * BYTES_PER_PIX;
    localparam int BW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [BW-1:0]    LAST = BW'(BYTES_PER_PIX - 1);
    localparam logic [CNT_W-1:0] XS   = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] XE   = CNT_W'(X_END);
    localparam logic [CNT_W-1:0] YS   = CNT_W'(Y_START);
    localparam logic [CNT_W-1:0] YE   = CNT_W'(Y_END);
    localparam logic [9:0]       SKIP = {2'b01, 8'(SKIP_FRAMES)};

    logic             href_q, vsync_q;
    logic [BW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [PW-1:0]    data_q, data_d;
    logic             valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic [CNT_W-1:0] ox_q, ox_d, oy_q, oy_d;
    logic             armed_q, armed_d, farm_q, farm_d;
    logic [7:0]       skip_q, skip_d, fcnt_q, fcnt_d;
    logic [CNT_W-1:0] len_q, len_d, lines_q, lines_d;
    logic             err_q, err_d;

    logic line_end, frame_end, active, done, in_x, in_y, emit;

    assign line_end  = href_q & ~iHREF;
    assign frame_end = ~vsync_q & iVSYNC;
    assign active    = ~iVSYNC & iHREF;
    assign done      = active && (idx_q == LAST);
    // Leading 1 keeps the lower-bound compares meaningful when the start is 0
    assign in_x = ({1'b1, x_q} >= {1'b1, XS}) && (x_q <= XE);
    assign in_y = ({1'b1, y_q} >= {1'b1, YS}) && (y_q <= YE);
    assign emit = done && armed_q && iInit_Done && in_x && in_y;

    always_comb begin
        idx_d   = '0;
        pix_d   = pix_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sof_d   = sof_q;
        eol_d   = eol_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        armed_d = armed_q;
        farm_d  = farm_q;
        skip_d  = skip_q;
        fcnt_d  = fcnt_q;
        len_d   = len_q;
        lines_d = lines_q;
        err_d   = err_q;

        if (active) begin
            idx_d = done ? '0 : idx_q + 1'b1;
            for (int i = 0; i < BYTES_PER_PIX; i++) begin
                if (idx_q == BW'((BYTE_SWAP != 0) ? i : BYTES_PER_PIX - 1 - i))
                    pix_d[i*IN_W +: IN_W] = iDATA;
            end
        end

        if (done && (x_q != '1))
            x_d = x_q + 1'b1;

        if (emit) begin
            valid_d = 1'b1;
            data_d  = pix_d;
            ox_d    = x_q - XS;
            oy_d    = y_q - YS;
            sof_d   = (x_q == XS) && (y_q == YS);
            eol_d   = (x_q == XE);
        end

        if (line_end) begin
            x_d = '0;
            if (x_q != '0) begin
                len_d = x_q;
                if (y_q != '1)
                    y_d = y_q + 1'b1;
            end
            if (idx_q != '0)
                err_d = 1'b1;
        end

        // Line accounting above runs first so a coincident line end is counted
        if (frame_end) begin
            lines_d = y_d;
            y_d     = '0;
            if (farm_q && iInit_Done)
                fcnt_d = fcnt_q + 1'b1;
        end

        if (!iInit_Done) begin
            skip_d  = '0;
            armed_d = 1'b0;
            farm_d  = 1'b0;
        end else if (frame_end) begin
            if (!armed_q) begin
                if (skip_q != 8'hFF)
                    skip_d = skip_q + 1'b1;
                if ({2'b01, skip_q} + 10'd1 >= SKIP)
                    armed_d = 1'b1;
            end
            farm_d = armed_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            idx_q   <= '0;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            armed_q <= 1'b0;
            farm_q  <= 1'b0;
            skip_q  <= '0;
            fcnt_q  <= '0;
            len_q   <= '0;
            lines_q <= '0;
            err_q   <= 1'b0;
        end else begin
            href_q  <= iHREF;
            vsync_q <= iVSYNC;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            armed_q <= armed_d;
            farm_q  <= farm_d;
            skip_q  <= skip_d;
            fcnt_q  <= fcnt_d;
            len_q   <= len_d;
            lines_q <= lines_d;
            err_q   <= err_d;
        end
    end

    assign oDATA        = data_q;
    assign oVALID       = valid_q;
    assign oSOF         = sof_q;
    assign oEOL         = eol_q;
    assign oX           = ox_q;
    assign oY           = oy_q;
    assign oARMED       = armed_q;
    assign oLINE_LEN    = len_q;
    assign oLINES       = lines_q;
    assign oFRAME_CNT   = fcnt_q;
    assign oERR_PARTIAL = err_q;

endmodule
